acc_poll_sequencer: RTL
=======================

# acc_poll_sequencer

Command-level sequencer for the accelerometer I2C path. It runs a one-time configuration write and then periodic 6-byte burst reads of the X/Y/Z output registers. It drives a byte-level I2C master engine through a single-outstanding command/response handshake and publishes each complete sample as three 16-bit words. It sits between the bit-level I2C engine (which owns SDA/SCL) and the flight-control logic that consumes acceleration data.

## Interface
- SLAVE_ADDR, 7'h19, 7-bit device address; write byte = {SLAVE_ADDR,0}, read byte = {SLAVE_ADDR,1}
- CFG_REG, 8'h20, register written once after reset
- CFG_DATA, 8'h57, value written to CFG_REG
- DATA_REG, 8'h28, first output register; sent as DATA_REG|8'h80 (auto-increment)
- PERIOD, 120000, clk12M cycles between read launches (100 Hz)
- BACKOFF, 1200, wait cycles after an error before retry
- clk12M  in  1  system clock, 12 MHz
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; permits starting new scripts
- cmd_valid  out  1  command offered to I2C engine
- cmd_ready  in  1  engine accepts command
- cmd_op  out  3  0=START (incl. repeated), 1=WRITE, 2=READ_ACK, 3=READ_NACK, 4=STOP
- cmd_wdata  out  8  byte for WRITE; 0 otherwise
- rsp_valid  in  1  one-cycle completion pulse, exactly one per accepted command
- rsp_rdata  in  8  read byte (valid with rsp_valid on READ_*)
- rsp_nack  in  1  slave NACKed (meaningful only for WRITE responses)
- acc_x, acc_y, acc_z  out  16 each  latest sample, {H,L} bytes
- sample_valid  out  1  one-cycle pulse when acc_* update
- configured  out  1  config write completed without NACK
- busy  out  1  a command script is in progress
- err_cnt  out  8  saturating count of NACK events

## Operation
- All outputs reset to 0. State resets to IDLE and step to 0. Reset may arrive mid-transaction; the engine shares rst and no recovery STOP is issued.
- States: IDLE, ISSUE, WAIT_RSP, PUBLISH, WAIT_PERIOD, ERR_STOP, ERR_RSP, BACKOFF.
- Config script, 5 steps: START, WRITE addrW, WRITE CFG_REG, WRITE CFG_DATA, STOP.
- Read script, 12 steps: START, WRITE addrW, WRITE DATA_REG|80, START, WRITE addrR, READ_ACK ×5, READ_NACK, STOP.
- IDLE with enable=1: run the config script if configured=0, otherwise the read script.
- ISSUE: hold cmd_valid/cmd_op/cmd_wdata stable until cmd_ready. The handshake moves to WAIT_RSP.
- WAIT_RSP, on rsp_valid:
  - WRITE with rsp_nack=1 → ERR_STOP.
  - Last step → config script: set configured, go to WAIT_PERIOD. Read script: go to PUBLISH.
  - Otherwise step+1 → ISSUE.
- rsp_nack on non-WRITE responses is ignored. rsp_valid outside WAIT_RSP/ERR_RSP is ignored.
- Read bytes are captured into a 6-byte shadow register in order X_L, X_H, Y_L, Y_H, Z_L, Z_H. acc_* are not touched until PUBLISH.
- PUBLISH (1 cycle): load all three acc_* words simultaneously, pulse sample_valid, go to WAIT_PERIOD.
- WAIT_PERIOD: count PERIOD cycles from entry, then go to IDLE. enable=0 → IDLE immediately.
- ERR_STOP: issue STOP. ERR_RSP: wait for its response, then err_cnt+1 (saturates at 255) → BACKOFF.
- BACKOFF: BACKOFF cycles → IDLE, which retries the full script from step 0. enable=0 → IDLE immediately. A failed read leaves acc_* at the previous sample.
- enable=0 during a script: the script completes, including error handling, then returns to IDLE and stays there.
- busy=1 in ISSUE, WAIT_RSP, PUBLISH, ERR_STOP, ERR_RSP.

## Timing
- cmd_* are registered. cmd_valid rises the cycle after entering ISSUE and falls the cycle after the cmd_valid&cmd_ready handshake.
- Exactly one command is outstanding. The next cmd_valid is no earlier than the cycle after rsp_valid.
- IDLE→ISSUE takes 1 cycle when enable=1.
- Final STOP rsp_valid → sample_valid: 1 cycle later (PUBLISH).
- Read launch period = PERIOD cycles from PUBLISH exit plus script duration. There is no drift compensation.
- Same-cycle rsp_valid and enable fall: the response is processed normally.

## Test plan
- Reset, enable=1, engine model ACKs everything (1-cycle ready, 5-cycle rsp):
  - First commands are START, WRITE 32h, WRITE 20h, WRITE 57h, STOP.
  - configured=1 after the STOP rsp.
  - No sample_valid yet.
- After config, rdata sequence 11,22,33,44,55,66:
  - Read script order is exact: START, WRITE 32h, WRITE A8h, START, WRITE 33h, READ_ACK ×5, READ_NACK, STOP.
  - sample_valid 1 cycle after the STOP rsp.
  - acc_x=2211h, acc_y=4433h, acc_z=6655h.
- NACK on WRITE 33h:
  - Next command is STOP; err_cnt=1.
  - No new command for BACKOFF cycles, then retry from START.
  - acc_* keep their prior values.
- Drop enable mid-read script:
  - The script finishes and the sample is published.
  - Then no further cmd_valid while enable=0.
- Hold cmd_ready=0 for 50 cycles on one command:
  - cmd_valid/op/wdata stay stable throughout.
  - Separately, assert rst mid-script: all outputs 0, configured=0, config script restarts.

Source files
------------

// File: rtl/acc_poll_sequencer.sv
// rtl/acc_poll_sequencer.sv - accelerometer I2C configure-then-poll command sequencer
//
// Runs a one-time register write to the accelerometer, then periodic 6-byte
// burst reads of X/Y/Z, driving a byte-level I2C engine one command at a time.
//
// Ports:
//   i_clk12M, i_rst            clock, asynchronous active-high reset
//   i_enable                   permits launching new command scripts
//   o_cmd_valid/i_cmd_ready    command handshake; o_cmd_op, o_cmd_wdata
//   i_rsp_valid                one-cycle completion per accepted command
//   i_rsp_rdata, i_rsp_nack    read byte / slave NACK for that command
//   o_acc_x/y/z, o_sample_valid  published sample and its update pulse
//   o_configured, o_busy, o_err_cnt  status
module acc_poll_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h19,
    parameter logic [7:0] CFG_REG    = 8'h20,
    parameter logic [7:0] CFG_DATA   = 8'h57,
    parameter logic [7:0] DATA_REG   = 8'h28,
    parameter int         PERIOD     = 120000,
    parameter int         BACKOFF    = 1200
) (
    input  logic        i_clk12M,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [2:0]  o_cmd_op,
    output logic [7:0]  o_cmd_wdata,
    input  logic        i_rsp_valid,
    input  logic [7:0]  i_rsp_rdata,
    input  logic        i_rsp_nack,
    output logic [15:0] o_acc_x,
    output logic [15:0] o_acc_y,
    output logic [15:0] o_acc_z,
    output logic        o_sample_valid,
    output logic        o_configured,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RSP, S_PUBLISH,
        S_WAIT_PERIOD, S_ERR_STOP, S_ERR_RSP, S_BACKOFF
    } state_t;

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    localparam int CNT_MAX = (PERIOD > BACKOFF) ? PERIOD : BACKOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PERIOD_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_step;
    logic            r_is_read;
    logic [CW-1:0]   r_cnt;
    logic [47:0]     r_shadow;
    logic            r_cmd_valid;
    logic [2:0]      r_cmd_op;
    logic [7:0]      r_cmd_wdata;
    logic [15:0]     r_acc_x, r_acc_y, r_acc_z;
    logic            r_sample_valid;
    logic            r_configured;
    logic [7:0]      r_err_cnt;

    logic [2:0]      w_op;
    logic [7:0]      w_wdata;
    logic            w_last;
    logic            w_handshake;
    logic            w_cv_next;
    logic            w_rsp_in_script;

    // Command table for the current step of the active script. ERR_STOP
    // always issues STOP regardless of where the script failed.
    always_comb begin
        w_op    = OP_STOP;
        w_wdata = 8'h00;
        if (r_state == S_ERR_STOP) begin
            w_op = OP_STOP;
        end else if (!r_is_read) begin
            case (r_step)
                4'd0:    w_op = OP_START;
                4'd1:    begin w_op = OP_WRITE; w_wdata = {SLAVE_ADDR, 1'b0}; end
                4'd2:    begin w_op = OP_WRITE; w_wdata = CFG_REG;            end
                4'd3:    begin w_op = OP_WRITE; w_wdata = CFG_DATA;           end
                default: w_op = OP_STOP;
            endcase
        end else begin
            case (r_step)
                4'd0, 4'd3:                    w_op = OP_START;
                4'd1:    begin w_op = OP_WRITE; w_wdata = {SLAVE_ADDR, 1'b0};  end
                4'd2:    begin w_op = OP_WRITE; w_wdata = DATA_REG | 8'h80;    end
                4'd4:    begin w_op = OP_WRITE; w_wdata = {SLAVE_ADDR, 1'b1};  end
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9:  w_op = OP_READ_ACK;
                4'd10:                         w_op = OP_READ_NACK;
                default:                       w_op = OP_STOP;
            endcase
        end
    end

    assign w_last          = r_is_read ? (r_step == 4'd11) : (r_step == 4'd4);
    assign w_handshake     = r_cmd_valid & i_cmd_ready;
    assign w_cv_next       = ((r_state == S_ISSUE) || (r_state == S_ERR_STOP)) && !w_handshake;
    assign w_rsp_in_script = (r_state == S_WAIT_RSP) && i_rsp_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (i_enable) w_next = S_ISSUE;
            S_ISSUE:       if (w_handshake) w_next = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (i_rsp_valid) begin
                    if ((w_op == OP_WRITE) && i_rsp_nack) w_next = S_ERR_STOP;
                    else if (w_last) w_next = r_is_read ? S_PUBLISH : S_WAIT_PERIOD;
                    else w_next = S_ISSUE;
                end
            end
            S_PUBLISH:     w_next = S_WAIT_PERIOD;
            S_WAIT_PERIOD: if (!i_enable || (r_cnt == PERIOD_LAST)) w_next = S_IDLE;
            S_ERR_STOP:    if (w_handshake) w_next = S_ERR_RSP;
            S_ERR_RSP:     if (i_rsp_valid) w_next = S_BACKOFF;
            S_BACKOFF:     if (!i_enable || (r_cnt == BACKOFF_LAST)) w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk12M or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_step         <= 4'd0;
            r_is_read      <= 1'b0;
            r_cnt          <= '0;
            r_shadow       <= 48'h0;
            r_cmd_valid    <= 1'b0;
            r_cmd_op       <= 3'd0;
            r_cmd_wdata    <= 8'h00;
            r_acc_x        <= 16'h0;
            r_acc_y        <= 16'h0;
            r_acc_z        <= 16'h0;
            r_sample_valid <= 1'b0;
            r_configured   <= 1'b0;
            r_err_cnt      <= 8'h00;
        end else begin
            r_state <= w_next;

            // Counter restarts on every entry to a timed wait state.
            if ((w_next == r_state) &&
                ((r_state == S_WAIT_PERIOD) || (r_state == S_BACKOFF)))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            r_cmd_valid <= w_cv_next;
            r_cmd_op    <= w_cv_next ? w_op    : 3'd0;
            r_cmd_wdata <= w_cv_next ? w_wdata : 8'h00;

            // Script type is fixed at launch so a mid-script status change
            // cannot switch tables underneath the running script.
            if ((r_state == S_IDLE) && i_enable) begin
                r_step    <= 4'd0;
                r_is_read <= r_configured;
            end else if (w_rsp_in_script && (w_next == S_ISSUE)) begin
                r_step <= r_step + 4'd1;
            end

            // Bytes shift in from the top, so after six reads X_L sits at [7:0].
            if (w_rsp_in_script && ((w_op == OP_READ_ACK) || (w_op == OP_READ_NACK)))
                r_shadow <= {i_rsp_rdata, r_shadow[47:8]};

            r_sample_valid <= (w_next == S_PUBLISH);
            if (w_next == S_PUBLISH) begin
                r_acc_x <= r_shadow[15:0];
                r_acc_y <= r_shadow[31:16];
                r_acc_z <= r_shadow[47:32];
            end

            if (w_rsp_in_script && (w_next == S_WAIT_PERIOD))
                r_configured <= 1'b1;

            if ((r_state == S_ERR_RSP) && i_rsp_valid && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_cmd_valid    = r_cmd_valid;
    assign o_cmd_op       = r_cmd_op;
    assign o_cmd_wdata    = r_cmd_wdata;
    assign o_acc_x        = r_acc_x;
    assign o_acc_y        = r_acc_y;
    assign o_acc_z        = r_acc_z;
    assign o_sample_valid = r_sample_valid;
    assign o_configured   = r_configured;
    assign o_err_cnt      = r_err_cnt;
    assign o_busy         = (r_state == S_ISSUE) || (r_state == S_WAIT_RSP) ||
                            (r_state == S_PUBLISH) || (r_state == S_ERR_STOP) ||
                            (r_state == S_ERR_RSP);
endmodule
